// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter and its priority selector.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N        = 8;
  localparam int ARB_MAX_HOLD = 16;

  // Binary index of the (single) set bit; 0 when no bit is set. Sized for N up to 16.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_sel.sv
// Combinational fixed-priority selector: the highest set request index wins.
module prio_sel #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic         req_up
);

  always_comb begin
    gnt = '0;
    // Ascending scan so the last (highest) set bit overwrites lower ones.
    for (int i = 0; i < N; i++) begin
      if (req[i]) gnt = N'(1) << i;
    end
    if (!en) gnt = '0;
  end

  assign req_up = |req;

endmodule

// File: rtl/rr_arb_ctrl.sv
// Registered round-robin arbiter with grant hold, done-release and hold-timeout revocation.
module rr_arb_ctrl
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout,
  output arb_state_t       dbg_state
);

  // Handshake: a grant is offered on gnt/gnt_valid and held until the winner
  // pulses done for one cycle (or the hold limit revokes it); no ready/backpressure.

  localparam int HC_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  logic [N-1:0] below_mask;
  logic [N-1:0] masked_req;
  logic [N-1:0] masked_gnt, raw_gnt, sel_gnt;
  logic         masked_up, raw_up;

  // Only indices strictly below the pointer get first chance; ptr=0 masks everything.
  assign below_mask = (N'(1) << ptr_q) - N'(1);
  assign masked_req = req & below_mask;

  prio_sel #(.N(N)) u_sel_masked (
    .req    (masked_req),
    .en     (en),
    .gnt    (masked_gnt),
    .req_up (masked_up)
  );

  prio_sel #(.N(N)) u_sel_raw (
    .req    (req),
    .en     (en),
    .gnt    (raw_gnt),
    .req_up (raw_up)
  );

  assign sel_gnt = masked_up ? masked_gnt : raw_gnt;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d     = '0;
        gnt_idx_d = '0;
        if (en && raw_up) begin
          gnt_d      = sel_gnt;
          gnt_idx_d  = IDX_W'(onehot_to_idx(16'(sel_gnt)));
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (done) begin
          gnt_d      = '0;
          gnt_idx_d  = '0;
          ptr_d      = gnt_idx_q;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
          gnt_d      = '0;
          gnt_idx_d  = '0;
          ptr_d      = gnt_idx_q;
          hold_cnt_d = '0;
          timeout_d  = 1'b1;
          state_d    = IDLE;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// Directed and randomized bench for rr_arb_ctrl against a transaction-level reference model.
module tb_rr_arb_ctrl;
  import arb_pkg::*;

  localparam int N        = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 16;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req   = '0;
  logic             en    = 1'b0;
  logic             done  = 1'b0;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;
  arb_state_t       dbg_state;

  always #5 clock = ~clock;

  rr_arb_ctrl #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .en        (en),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [IDX_W-1:0] exp_q[$];

  // Reference model: who holds the resource, since how long, and where rotation resumes.
  bit m_busy   = 1'b0;
  int m_owner  = 0;
  int m_age    = 0;
  int m_ptr    = 0;
  bit m_to     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk downward from just below the rotation point, wrapping around the top.
  function automatic int pick(input logic [N-1:0] r, input int p);
    int i;
    for (int d = 1; d <= N; d++) begin
      i = (p - d + N) % N;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic e, input logic d, input logic rst);
    if (rst) begin
      m_busy = 0; m_owner = 0; m_age = 0; m_ptr = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      if (e && r != 0) begin
        m_busy = 1; m_owner = pick(r, m_ptr); m_age = 0;
      end
    end else begin
      m_to = 0;
      if (d) begin
        m_busy = 0; m_ptr = m_owner;
      end else if (MAX_HOLD != 0 && m_age + 1 == MAX_HOLD) begin
        m_busy = 0; m_ptr = m_owner; m_to = 1;
      end else begin
        m_age++;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [N-1:0] r, input logic e, input logic d, input logic rst);
    req = r; en = e; done = d; reset = rst;
    @(posedge clock);
    model_edge(r, e, d, rst);
    #1;
    check("gnt",       32'(gnt),       m_busy ? 32'(1) << m_owner : 32'd0);
    check("gnt_idx",   32'(gnt_idx),   m_busy ? 32'(m_owner) : 32'd0);
    check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
    check("timeout",   32'(timeout),   32'(m_to));
  endtask

  logic [31:0] exp_idx;
  bit          prev_valid;
  logic [N-1:0] rr;
  logic         re, rd, rrst;

  initial begin
    #1;
    // Reset state
    step('0, 0, 0, 1);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // 1: full request vector, rotation 7..0 then wrap to 7, idle gap between grants
    exp_q = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    prev_valid = 0;
    for (int c = 0; c < 26; c++) begin
      step(8'hFF, 1, (m_busy && m_age == 1), 0);
      if (gnt_valid && !prev_valid) begin
        exp_idx = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
        check("t1_order", 32'(gnt_idx), exp_idx);
      end
      prev_valid = gnt_valid;
    end
    check("t1_all_grants_seen", 32'(exp_q.size()), 0);

    // 2: enable low blocks new grants
    step('0, 0, 0, 1);
    for (int c = 0; c < 5; c++) begin
      step(8'b0010_0100, 0, 0, 0);
      check("t2_en_low", 32'(gnt), 0);
    end
    step(8'b0010_0100, 1, 0, 0);
    check("t2_gnt", 32'(gnt), 32'h20);
    check("t2_idx", 32'(gnt_idx), 5);

    // 3: grant held across request changes
    step('0, 0, 0, 1);
    step(8'h08, 1, 0, 0);
    for (int c = 0; c < 4; c++) begin
      step(8'h40, 1, 0, 0);
      check("t3_hold", 32'(gnt), 32'h08);
    end
    step(8'h40, 1, 1, 0);
    check("t3_release", 32'(gnt_valid), 0);
    step(8'h40, 1, 0, 0);
    check("t3_next", 32'(gnt), 32'h40);

    // 4: hold timeout after MAX_HOLD cycles
    step('0, 0, 0, 1);
    step(8'h04, 1, 0, 0);
    for (int c = 0; c < MAX_HOLD - 1; c++) begin
      step(8'h0F, 1, 0, 0);
      check("t4_held", 32'(gnt), 32'h04);
    end
    step(8'h0F, 1, 0, 0);
    check("t4_revoked", 32'(gnt), 0);
    check("t4_timeout", 32'(timeout), 1);
    step(8'h0F, 1, 0, 0);
    check("t4_timeout_once", 32'(timeout), 0);
    check("t4_next", 32'(gnt), 32'h02);

    // 5: done on the timeout cycle wins
    step('0, 0, 0, 1);
    step(8'h30, 1, 0, 0);
    for (int c = 0; c < MAX_HOLD - 1; c++) step(8'h30, 1, 0, 0);
    step(8'h30, 1, 1, 0);
    check("t5_no_timeout", 32'(timeout), 0);
    check("t5_released", 32'(gnt_valid), 0);
    step(8'h30, 1, 0, 0);
    check("t5_next", 32'(gnt), 32'h10);

    // 6: reset during a grant clears the pointer
    step('0, 0, 0, 1);
    step(8'h10, 1, 0, 0);
    step(8'h10, 1, 1, 0);
    step(8'h11, 1, 0, 0);
    check("t6_rotated", 32'(gnt), 32'h01);
    step(8'h11, 1, 0, 1);
    check("t6_reset_gnt", 32'(gnt), 0);
    step(8'h11, 1, 0, 0);
    check("t6_after_reset", 32'(gnt_idx), 4);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rr   = N'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rr = '0;
      re   = ($urandom_range(0, 3) != 0);
      rd   = ($urandom_range(0, 5) == 0);
      rrst = ($urandom_range(0, 99) == 0);
      step(rr, re, rd, rrst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
